// File: rtl/mul32_iter_if.sv
// Start/done handshake bundle for the iterative RV32M multiplier.
//   start  : request pulse, accepted only while the multiplier is idle
//   op     : funct3[1:0] (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU)
//   a_in   : multiplicand (rs1)
//   b_in   : multiplier (rs2)
//   result : selected half of the 2*WIDTH product, valid with done
//   busy   : high from the accept edge until done
//   done   : one-cycle completion pulse
interface mul32_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    // Requester side (ALU issue logic or testbench)
    modport master (
        output start, op, a_in, b_in,
        input  result, busy, done
    );

    // Multiplier side
    modport slave (
        input  start, op, a_in, b_in,
        output result, busy, done
    );
endinterface

// File: rtl/mul32_iter.sv
// Iterative radix-4 multiplier for MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes two bits per cycle with an unsigned shift-add
// datapath, then applies the sign correction in a final FIX cycle.
// Fixed latency: WIDTH/2 CALC cycles plus one FIX cycle after the accept edge.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : mul32_iter_if slave modport (start/op/a_in/b_in in, result/busy/done out)
module mul32_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mul32_iter_if.slave   bus
);
    localparam int unsigned ITER   = WIDTH / 2;
    localparam int unsigned CNT_W  = $clog2(ITER + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned PP_W   = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic                neg_q, neg_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                a_neg_c, b_neg_c;
    logic [PP_W-1:0]     pp_c;
    logic [CNT_W-1:0]    idx_c;
    logic [CNT_W:0]      shamt_c;
    logic [PROD_W-1:0]   prod_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = S_CALC;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand sign handling: rs1 is signed for MULH/MULHSU, rs2 only for MULH
    assign a_neg_c = ((bus.op == 2'b01) || (bus.op == 2'b10)) && bus.a_in[WIDTH-1];
    assign b_neg_c = (bus.op == 2'b01) && bus.b_in[WIDTH-1];

    // Radix-4 partial product: mcand * multiplier digit, 0..3
    always_comb begin
        pp_c = '0;
        unique case (mplier_q[1:0])
            2'd0: pp_c = '0;
            2'd1: pp_c = {2'b00, mcand_q};
            2'd2: pp_c = {1'b0, mcand_q, 1'b0};
            2'd3: pp_c = {1'b0, mcand_q, 1'b0} + {2'b00, mcand_q};
            default: pp_c = '0;
        endcase
    end

    // Digit position grows as the counter runs down from ITER
    assign idx_c   = CNT_W'(ITER) - cnt_q;
    assign shamt_c = {idx_c, 1'b0};
    assign prod_c  = neg_q ? (~acc_q + PROD_W'(1)) : acc_q;

    // Datapath and output next values
    always_comb begin
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    mcand_d  = a_neg_c ? (~bus.a_in + WIDTH'(1)) : bus.a_in;
                    mplier_d = b_neg_c ? (~bus.b_in + WIDTH'(1)) : bus.b_in;
                    neg_d    = a_neg_c ^ b_neg_c;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(ITER);
                    busy_d   = 1'b1;
                end
            end
            S_CALC: begin
                acc_d    = acc_q + (PROD_W'(pp_c) << shamt_c);
                mplier_d = mplier_q >> 2;
                cnt_d    = cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                result_d = (op_q == 2'b00) ? prod_c[WIDTH-1:0] : prod_c[PROD_W-1:WIDTH];
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: doc/mul32_iter.md
Name: mul32_iter

Overview:
- Iterative radix-4 integer multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
- It is the multiply counterpart to the team's iterative divider and sits beside it in the ALU's M-extension path.
- Uses the same start/done handshake and a fixed, deterministic latency.
- Works on operand magnitudes with an unsigned shift-add datapath, then applies two's-complement correction at the end.

Parameters:
- WIDTH, 32: operand width. Must be even. Iteration count is WIDTH/2.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse. Accepted only in IDLE.
- op  input  2  funct3[1:0] encoding: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- a_in  input  WIDTH  multiplicand (rs1).
- b_in  input  WIDTH  multiplier (rs2).
- result  output  WIDTH  selected half of the 2*WIDTH product.
- busy  output  1  high from the accept edge until done is asserted.
- done  output  1  one-cycle pulse; result is valid in the same cycle.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE.
  - result, busy, done, accumulator, counter and all latched operands/flags = 0.
  - rst overrides everything, including mid-operation. In-flight work is discarded and no done is produced.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - On an edge with start=1, latch op.
  - Latch a_signed = op==01 or op==10, and b_signed = op==01.
  - Latch magnitudes: |a| if a_signed and a_in[WIDTH-1]=1, else a_in; same rule for b.
  - Latch neg = (a_signed & a_in[WIDTH-1]) ^ (b_signed & b_in[WIDTH-1]).
  - Clear the 2*WIDTH accumulator, set counter=WIDTH/2, set busy=1, go to CALC.
  - Magnitude of the most-negative value (0x80000000) is 0x80000000 treated as unsigned. No special case is needed.
- CALC (one iteration per edge):
  - d = low 2 bits of the remaining multiplier magnitude.
  - Add (mcand*d) << (2*iteration index) into the accumulator.
  - Shift the multiplier right by 2 and decrement the counter.
  - mcand*d is formed as 0, mcand, mcand<<1, or (mcand<<1)+mcand, in WIDTH+2 bits.
  - The accumulator never overflows 2*WIDTH bits.
  - After the edge where the counter reaches 0, go to FIX.
  - No early termination: latency is fixed.
- FIX (one edge):
  - prod = neg ? (~acc + 1) : acc, taken modulo 2^(2*WIDTH).
  - result = prod[WIDTH-1:0] for op 00; otherwise result = prod[2*WIDTH-1:WIDTH].
  - done=1, busy=0, state=IDLE.
- Done pulse:
  - done drops to 0 on the next edge.
  - result holds its value until the next FIX or reset.
- Latency: start accepted at edge T0 gives CALC on edges T1..T16 and FIX on T17. done and result are visible after T17, i.e. 17 clocks for WIDTH=32.
- Input sampling: a_in, b_in and op are sampled only at the accept edge. Later changes have no effect.
- start while busy: ignored, with no queuing.
- start in the same cycle done=1: state is already IDLE, so the request is accepted. Back-to-back throughput is one result per 18 cycles.
- Division-by-zero-style special cases: none. Every input pair produces the mathematically correct product modulo 2^64.

Test Plan:
- MUL, a=7, b=6 -> after 17 clocks, done=1 for exactly one cycle, result=0x0000002A, busy low in the done cycle.
- MULH, a=0x80000000, b=0x80000000 -> result=0x40000000. MUL with the same operands -> result=0x00000000.
- MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- MULHSU, a=0xFFFFFFFF (-1), b=0xFFFFFFFF (unsigned) -> result=0xFFFFFFFF. MULH with the same operands -> 0x00000000. MUL with a=0xFFFFFFFD (-3), b=5 -> 0xFFFFFFF1.
- Handshake: MUL 3*4 started, then start with a=9, b=9 pulsed at cycle 5 while busy -> ignored, result=0x0000000C. A new start asserted in the done cycle is accepted and yields 81 seventeen cycles later.
- Reset mid-op: rst high at cycle 8 of a MULHU -> next edge gives result=0, busy=0, done=0, and no done pulse follows. A subsequent MUL 2*3 returns 6.
